pbit_sampler: RTL and testbench

//  Stochastic output stage of a p-bit. It consumes the signed tanh activation
//  (s.[OUT_BITS-1] fixed point, range -1 to almost 1) produced by the

---
 rtl/pbit_pkg.sv | 50 +++++
 rtl/pbit_lfsr.sv | 64 ++++++
 rtl/pbit_sampler.sv | 177 +++++++++++++++++
 tb/tb_pbit_sampler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// ---------------------------------------------------------------------------
// pbit_pkg
//   Shared constants and helpers for the p-bit datapath.
//
//   - Default Galois feedback masks for the LFSR widths in use. Each mask
//     gives a maximal-length sequence (2**W - 1 states) for a right-shifting
//     Galois LFSR of that width.
//   - pbit_default_taps(width): picks the default mask for a given width.
//   - SEED_FIX(seed): an all-zero LFSR state is a lock-up state, so a zero
//     seed is mapped to 1. Every other seed passes through unchanged.
//
//   The helpers work on 64-bit values so that one definition serves every
//   LFSR width up to 64 bits. Callers cast the result to their own width.
// ---------------------------------------------------------------------------
package pbit_pkg;

  localparam logic [7:0]  LFSR_TAPS_W8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_W16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_W32 = 32'h80200003;

  // Widest LFSR the helpers below can describe.
  localparam int LFSR_MAX_BITS = 64;

  // Default feedback mask for a given LFSR width. An unsupported width
  // returns 0, which turns the LFSR into a plain shifter; the sampler checks
  // for that at elaboration time.
  function automatic logic [LFSR_MAX_BITS-1:0] pbit_default_taps(input int width);
    logic [LFSR_MAX_BITS-1:0] taps;
    taps = '0;
    case (width)
      8:       taps = LFSR_MAX_BITS'(LFSR_TAPS_W8);
      16:      taps = LFSR_MAX_BITS'(LFSR_TAPS_W16);
      32:      taps = LFSR_MAX_BITS'(LFSR_TAPS_W32);
      default: taps = '0;
    endcase
    return taps;
  endfunction

  // Map the illegal all-zero seed to 1 so the LFSR can never start in its
  // lock-up state.
  function automatic logic [LFSR_MAX_BITS-1:0] SEED_FIX(input logic [LFSR_MAX_BITS-1:0] seed);
    logic [LFSR_MAX_BITS-1:0] fixed;
    fixed = seed;
    if (seed == '0) begin
      fixed = LFSR_MAX_BITS'(1);
    end
    return fixed;
  endfunction

endpackage : pbit_pkg

// File: rtl/pbit_lfsr.sv
// ---------------------------------------------------------------------------
// pbit_lfsr
//   Galois right-shift LFSR that supplies the uniform random number for the
//   p-bit comparator.
//
//   next = (value >> 1) ^ (value[0] ? TAPS : 0)
//
//   The register advances only on cycles with en=1, so the sequence seen by
//   the sampler depends only on the number of samples taken since reset,
//   not on how those samples are spaced in time.
//
//   With a maximal-length TAPS mask the state walks through every nonzero
//   value exactly once per 2**WIDTH - 1 steps and never reaches zero.
//
// Parameters
//   WIDTH  register width
//   TAPS   Galois feedback mask
//   SEED   reset value (0 is replaced by 1)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous, active-low reset (loads the seed)
//   en     in   1      advance one step at this edge
//   value  out  WIDTH  current LFSR state
// ---------------------------------------------------------------------------
module pbit_lfsr
  import pbit_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(pbit_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  // Seed actually loaded at reset, with the zero seed already repaired.
  localparam logic [WIDTH-1:0] RESET_VALUE = WIDTH'(SEED_FIX(LFSR_MAX_BITS'(SEED)));

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_next;

  // Galois step: shift right and fold the feedback mask in when the bit
  // leaving the register is 1.
  always_comb begin
    state_next = state_q >> 1;
    if (state_q[0]) begin
      state_next = state_next ^ TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_VALUE;
    end else if (en) begin
      state_q <= state_next;
    end
  end

  assign value = state_q;

endmodule : pbit_lfsr

// File: rtl/pbit_sampler.sv
// ---------------------------------------------------------------------------
// pbit_sampler
//   Stochastic output stage of a p-bit.
//
//   On each update strobe the signed tanh activation is compared against a
//   uniform pseudo-random number (the LFSR state read as a signed value) and
//   the result is registered as the binary p-bit state m:
//
//     m <= ($signed(tanh_in) > $signed(rnd))
//
//   which makes P(m = 1) close to (1 + tanh_in) / 2. The compare is strict,
//   so the most negative activation always yields m = 0 and the most
//   positive activation yields m = 1 except when rnd equals it.
//
//   A window counter sums the ones over 2**WIN_LOG2 consecutive samples and
//   publishes the total on mean_count when a window completes.
//
// Strobe/pulse protocol
//   update_en is a one-cycle strobe with no back-pressure: each cycle it is
//   high at a rising edge consumes exactly one sample of tanh_in. There is no
//   ready. The outputs answer with one-cycle pulses in the following cycle:
//   m_valid on every sample, mean_valid (coincident with m_valid) on the
//   sample that completes a window. m and mean_count hold between pulses.
//   tanh_in only matters on cycles where update_en is high.
//
// Parameters
//   TANH_BITS  width of tanh_in and of the LFSR
//   LFSR_TAPS  Galois feedback mask (maximal length for TANH_BITS)
//   SEED       LFSR reset value (0 is replaced by 1)
//   WIN_LOG2   window length = 2**WIN_LOG2 samples
//
// Ports
//   clk         in   1            rising-edge clock
//   rst_n       in   1            synchronous, active-low reset
//   tanh_in     in   TANH_BITS    signed activation (s.[TANH_BITS-1] fixed point)
//   update_en   in   1            take one sample this cycle
//   win_clear   in   1            restart the counting window
//   m           out  1            registered p-bit state (1 = +1, 0 = -1)
//   m_valid     out  1            one-cycle pulse: m updated
//   mean_count  out  WIN_LOG2+1   number of ones in the last complete window
//   mean_valid  out  1            one-cycle pulse: mean_count updated
// ---------------------------------------------------------------------------
module pbit_sampler
  import pbit_pkg::*;
#(
  parameter int                   TANH_BITS = 32,
  parameter logic [TANH_BITS-1:0] LFSR_TAPS = TANH_BITS'(pbit_default_taps(TANH_BITS)),
  parameter logic [TANH_BITS-1:0] SEED      = TANH_BITS'(1),
  parameter int                   WIN_LOG2  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TANH_BITS-1:0] tanh_in,
  input  logic                 update_en,
  input  logic                 win_clear,
  output logic                 m,
  output logic                 m_valid,
  output logic [WIN_LOG2:0]    mean_count,
  output logic                 mean_valid
);

  // -------------------------------------------------------------------------
  // Elaboration-time sanity checks
  // -------------------------------------------------------------------------
  if (TANH_BITS < 2 || TANH_BITS > LFSR_MAX_BITS) begin : g_bad_width
    $error("pbit_sampler: TANH_BITS must be in 2..%0d", LFSR_MAX_BITS);
  end
  if (LFSR_TAPS == '0) begin : g_bad_taps
    $error("pbit_sampler: LFSR_TAPS must be nonzero");
  end
  if (WIN_LOG2 < 1) begin : g_bad_win
    $error("pbit_sampler: WIN_LOG2 must be at least 1");
  end

  // -------------------------------------------------------------------------
  // Random number source
  // -------------------------------------------------------------------------
  logic [TANH_BITS-1:0] rnd;

  // The LFSR steps on the same edge that consumes a sample, so the value
  // compared at sample k is always the k-th state after reset.
  pbit_lfsr #(
    .WIDTH (TANH_BITS),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (update_en),
    .value (rnd)
  );

  // -------------------------------------------------------------------------
  // Comparator
  // -------------------------------------------------------------------------
  logic cmp;

  // Full-width strict signed compare. Both operands are two's complement
  // values in [-1, 1) of the same fixed-point format.
  assign cmp = $signed(tanh_in) > $signed(rnd);

  // -------------------------------------------------------------------------
  // p-bit state register
  // -------------------------------------------------------------------------
  logic m_q;
  logic m_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q       <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= update_en;
      if (update_en) begin
        m_q <= cmp;
      end
    end
  end

  assign m       = m_q;
  assign m_valid = m_valid_q;

  // -------------------------------------------------------------------------
  // Window counter
  // -------------------------------------------------------------------------
  // idx counts samples already in the current window (0 .. 2**WIN_LOG2-1).
  // count holds the ones among them; it needs WIN_LOG2+1 bits because the
  // completed total can reach 2**WIN_LOG2.
  logic [WIN_LOG2-1:0] idx_q;
  logic [WIN_LOG2:0]   count_q;
  logic [WIN_LOG2:0]   mean_count_q;
  logic                mean_valid_q;

  logic [WIN_LOG2:0]   cmp_ext;
  logic [WIN_LOG2:0]   count_sum;
  logic                idx_last;

  assign cmp_ext   = {{WIN_LOG2{1'b0}}, cmp};
  assign count_sum = count_q + cmp_ext;
  assign idx_last  = &idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      count_q      <= '0;
      mean_count_q <= '0;
      mean_valid_q <= 1'b0;
    end else begin
      mean_valid_q <= 1'b0;
      if (win_clear) begin
        // A clear always wins over window completion: the partial window is
        // dropped and, if a sample is taken now, it opens the new window.
        if (update_en) begin
          count_q <= cmp_ext;
          idx_q   <= WIN_LOG2'(1);
        end else begin
          count_q <= '0;
          idx_q   <= '0;
        end
      end else if (update_en) begin
        if (idx_last) begin
          mean_count_q <= count_sum;
          mean_valid_q <= 1'b1;
          count_q      <= '0;
          idx_q        <= '0;
        end else begin
          count_q <= count_sum;
          idx_q   <= idx_q + WIN_LOG2'(1);
        end
      end
    end
  end

  assign mean_count = mean_count_q;
  assign mean_valid = mean_valid_q;

endmodule : pbit_sampler

// File: tb/tb_pbit_sampler.sv
// ---------------------------------------------------------------------------
// tb_pbit_sampler
//   Bench for pbit_sampler with TANH_BITS=8, LFSR_TAPS=8'hB8, SEED=8'h01,
//   WIN_LOG2=4. A behavioural model (random-number walk as plain integer
//   arithmetic, window as a queue of sample bits) predicts every output each
//   cycle; window totals also go through an expected queue.
// ---------------------------------------------------------------------------
module tb_pbit_sampler;

  localparam int WIN = 16;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tanh_in = 8'h00;
  logic       update_en = 1'b0;
  logic       win_clear = 1'b0;
  logic       m;
  logic       m_valid;
  logic [4:0] mean_count;
  logic       mean_valid;

  always #5 clk = ~clk;

  pbit_sampler #(
    .TANH_BITS (8),
    .LFSR_TAPS (8'hB8),
    .SEED      (8'h01),
    .WIN_LOG2  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tanh_in    (tanh_in),
    .update_en  (update_en),
    .win_clear  (win_clear),
    .m          (m),
    .m_valid    (m_valid),
    .mean_count (mean_count),
    .mean_valid (mean_valid)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int         n_vec = 0;
  int         n_bad = 0;
  logic [4:0] exp_q[$];
  int         ones = 0;
  int         mean_pulses = 0;
  int         mvalid_pulses = 0;
  logic       m_seq[$];

  // Reference model state
  int         mdl_lfsr = 1;
  logic       mdl_m = 1'b0;
  logic       mdl_mv = 1'b0;
  logic       mdl_meanv = 1'b0;
  int         mdl_mean = 0;
  int         mdl_win[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, computed from the sampling rules directly.
  task automatic model_edge(input logic r, input logic u, input logic c, input logic [7:0] t);
    int rnd;
    int ti;
    int sum;
    logic bit_v;
    if (!r) begin
      mdl_lfsr  = 1;
      mdl_m     = 1'b0;
      mdl_mv    = 1'b0;
      mdl_meanv = 1'b0;
      mdl_mean  = 0;
      mdl_win.delete();
    end else begin
      mdl_mv    = u;
      mdl_meanv = 1'b0;
      bit_v     = 1'b0;
      if (u) begin
        rnd   = (mdl_lfsr >= 128) ? mdl_lfsr - 256 : mdl_lfsr;
        ti    = (t >= 8'd128) ? int'(t) - 256 : int'(t);
        bit_v = (ti > rnd);
        mdl_m = bit_v;
        mdl_lfsr = (mdl_lfsr % 2 == 1) ? ((mdl_lfsr / 2) ^ 'hB8) : (mdl_lfsr / 2);
      end
      if (c) begin
        mdl_win.delete();
        if (u) mdl_win.push_back(int'(bit_v));
      end else if (u) begin
        mdl_win.push_back(int'(bit_v));
        if (mdl_win.size() == WIN) begin
          sum = 0;
          foreach (mdl_win[k]) sum += mdl_win[k];
          mdl_mean  = sum;
          mdl_meanv = 1'b1;
          exp_q.push_back(5'(sum));
          mdl_win.delete();
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, advance the model, compare outputs.
  // -------------------------------------------------------------------------
  task automatic drive(input logic r, input logic u, input logic c, input logic [7:0] t);
    logic [4:0] e;
    rst_n     = r;
    update_en = u;
    win_clear = c;
    tanh_in   = t;
    @(posedge clk);
    #1;
    model_edge(r, u, c, t);
    check("m", 32'(m), 32'(mdl_m));
    check("m_valid", 32'(m_valid), 32'(mdl_mv));
    check("mean_valid", 32'(mean_valid), 32'(mdl_meanv));
    check("mean_count", 32'(mean_count), 32'(mdl_mean));
    if (mean_valid === 1'b1) begin
      mean_pulses++;
      if (exp_q.size() == 0) begin
        check("mean_q_unexpected", 32'(mean_count), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("mean_q", 32'(mean_count), 32'(e));
      end
    end
    if (m_valid === 1'b1) begin
      mvalid_pulses++;
      m_seq.push_back(m);
      if (m === 1'b1) ones++;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    exp_q.delete();
    ones = 0;
    mean_pulses = 0;
    mvalid_pulses = 0;
    m_seq.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  // -------------------------------------------------------------------------
  // Table of first samples after reset. rnd walks 01,B8,5C,2E,17,B3,E1,C8,
  // 64,32 (signed 1,-72,92,46,23,-77,-31,-56,100,50).
  // -------------------------------------------------------------------------
  typedef struct {
    logic [7:0] tanh;
    logic       exp_m;
  } vec_t;

  vec_t tbl[10];

  logic [7:0] stim[20];
  logic       seq_a[$];

  initial begin
    tbl[0] = '{8'h00, 1'b0};  // 0 > 1 false
    tbl[1] = '{8'h00, 1'b1};  // 0 > -72
    tbl[2] = '{8'h5D, 1'b1};  // 93 > 92
    tbl[3] = '{8'h2E, 1'b0};  // 46 > 46 false (strict)
    tbl[4] = '{8'h80, 1'b0};  // -128 > 23 false
    tbl[5] = '{8'hB3, 1'b0};  // -77 > -77 false
    tbl[6] = '{8'hE2, 1'b1};  // -30 > -31
    tbl[7] = '{8'h7F, 1'b1};  // 127 > -56
    tbl[8] = '{8'h64, 1'b0};  // 100 > 100 false
    tbl[9] = '{8'h33, 1'b1};  // 51 > 50

    // 1. Reset held 3 cycles with update_en high.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h7F);
      check("rst_m", 32'(m), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_mean_valid", 32'(mean_valid), 32'd0);
      check("rst_mean_count", 32'(mean_count), 32'd0);
    end

    // Table-driven vectors directly after reset release.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, tbl[i].tanh);
      check("tbl_m", 32'(m), 32'(tbl[i].exp_m));
      check("tbl_m_valid", 32'(m_valid), 32'd1);
    end

    // 2. Period / fairness.
    do_reset();
    for (int i = 0; i < 255; i++) drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("period_ones", 32'(ones), 32'd128);
    drive(1'b1, 1'b1, 1'b0, 8'h01);  // rnd back at 01: 1 > 1 false
    check("period_wrap_m", 32'(m), 32'd0);

    // 3. Saturation.
    do_reset();
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 1'b0, 8'h80);
    check("sat_neg_ones", 32'(ones), 32'd0);
    check("sat_neg_pulses", 32'(mean_pulses), 32'd2);
    check("sat_neg_mean", 32'(mean_count), 32'd0);
    do_reset();
    for (int i = 0; i < 255; i++) drive(1'b1, 1'b1, 1'b0, 8'h7F);
    check("sat_pos_ones", 32'(ones), 32'd254);

    // 4. Window from reset.
    do_reset();
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 8'h7F);
    check("win_early_pulses", 32'(mean_pulses), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h7F);
    check("win_pulse_now", 32'(mean_valid), 32'd1);
    check("win_mean", 32'(mean_count), 32'd16);
    idle(1);
    check("win_pulse_once", 32'(mean_pulses), 32'd1);
    check("win_mean_hold", 32'(mean_count), 32'd16);

    // 5. Gapped strobes versus back-to-back with the same activations.
    for (int i = 0; i < 20; i++) stim[i] = 8'($urandom_range(0, 255));
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, stim[i]);
    seq_a = m_seq;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, stim[i]);
      idle(2);
    end
    check("gap_mvalid_count", 32'(mvalid_pulses), 32'd20);
    for (int i = 0; i < 20; i++) begin
      check("gap_vs_b2b", 32'(m_seq[i]), 32'(seq_a[i]));
    end

    // 6a. win_clear with update_en at idx=15.
    do_reset();
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    drive(1'b1, 1'b1, 1'b1, 8'h7F);
    check("clr_coll_no_pulse", 32'(mean_valid), 32'd0);
    check("clr_coll_m_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    check("clr_coll_early", 32'(mean_pulses), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h7F);
    check("clr_coll_pulse", 32'(mean_pulses), 32'd1);

    // 6b. win_clear without update mid-window.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    check("clr_idle_m_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    check("clr_idle_early", 32'(mean_pulses), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("clr_idle_pulse", 32'(mean_pulses), 32'd1);

    // 6c. Reset at idx=10 discards the partial window.
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    do_reset();
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    check("rst_mid_early", 32'(mean_pulses), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    check("rst_mid_pulse", 32'(mean_pulses), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 15) == 0),
            8'($urandom_range(0, 255)));
    end

    idle(2);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pbit_sampler
